// File: rtl/uart_tx_buffer_pkg.sv
// Shared definitions for the UART transmit buffer: default widths and the
// drain FSM state encoding.
package uart_tx_buffer_pkg;

    localparam int unsigned TXB_DATA_W  = 8;
    localparam int unsigned TXB_DEPTH_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2,
        ST_WAIT  = 2'd3
    } txb_state_e;

endpackage

// File: rtl/uart_tx_buffer_mem.sv
// Simple dual-port register array for the TX buffer: synchronous write,
// asynchronous read. Contents are not reset.
module uart_tx_buffer_mem
    import uart_tx_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = TXB_DATA_W,
    parameter int unsigned ADDR_W = TXB_DEPTH_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/uart_tx_buffer.sv
// UART transmit buffer: circular byte queue filled by TXDATA writes and
// drained one byte at a time into the uart_core through a 4-state handshake FSM.
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int unsigned DATA_W  = TXB_DATA_W,
    parameter int unsigned DEPTH_W = TXB_DEPTH_W
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic              rst_soft_i,
    input  logic              tx_en_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DEPTH_W:0]  level_o,
    output logic              overflow_o,
    input  logic              ovf_clr_i,
    input  logic              core_ready_i,
    output logic [DATA_W-1:0] core_data_o,
    output logic              core_wen_o
);

    localparam logic [DEPTH_W:0]   LVL_FULL = {1'b1, {DEPTH_W{1'b0}}};
    localparam logic [DEPTH_W:0]   LVL_ONE  = {{DEPTH_W{1'b0}}, 1'b1};
    localparam logic [DEPTH_W-1:0] PTR_ONE  = LVL_ONE[DEPTH_W-1:0];

    txb_state_e          r_state;
    logic [DEPTH_W-1:0]  r_wr_ptr;
    logic [DEPTH_W-1:0]  r_rd_ptr;
    logic [DEPTH_W:0]    r_level;
    logic                r_overflow;
    logic [DATA_W-1:0]   r_core_data;
    logic                r_core_wen;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_drop;
    logic                w_pop;
    logic                w_mem_we;
    logic [DATA_W-1:0]   w_rd_data;

    // Full/empty come from the current level, so a push at full is dropped
    // even when a pop happens in the same cycle.
    assign w_full   = (r_level == LVL_FULL);
    assign w_empty  = (r_level == '0);
    assign w_push   = wr_en_i & ~w_full;
    assign w_drop   = wr_en_i & w_full;
    assign w_pop    = (r_state == ST_IDLE) & ~w_empty & tx_en_i & core_ready_i;
    assign w_mem_we = cke_i & ~rst_soft_i & w_push;

    uart_tx_buffer_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (w_mem_we),
        .waddr_i (r_wr_ptr),
        .wdata_i (wr_data_i),
        .raddr_i (r_rd_ptr),
        .rdata_o (w_rd_data)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_wr_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (cke_i) begin
            if (rst_soft_i) begin
                r_wr_ptr   <= '0;
                r_level    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LVL_ONE;
                    2'b01:   r_level <= r_level - LVL_ONE;
                    default: r_level <= r_level;
                endcase
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end else if (ovf_clr_i) begin
                    r_overflow <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state     <= ST_IDLE;
            r_rd_ptr    <= '0;
            r_core_data <= '0;
            r_core_wen  <= 1'b0;
        end else if (cke_i) begin
            if (rst_soft_i) begin
                r_state    <= ST_IDLE;
                r_rd_ptr   <= '0;
                r_core_wen <= 1'b0;
            end else begin
                r_core_wen <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (w_pop) begin
                            r_state     <= ST_ISSUE;
                            r_core_data <= w_rd_data;
                            r_rd_ptr    <= r_rd_ptr + PTR_ONE;
                            r_core_wen  <= 1'b1;
                        end
                    end
                    // GUARD gives the core one cycle to drop ready before it is sampled
                    ST_ISSUE: r_state <= ST_GUARD;
                    ST_GUARD: r_state <= ST_WAIT;
                    ST_WAIT: begin
                        if (core_ready_i) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign level_o     = r_level;
    assign overflow_o  = r_overflow;
    assign core_data_o = r_core_data;
    assign core_wen_o  = r_core_wen;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed self-checking bench for uart_tx_buffer (DATA_W=8, DEPTH_W=4).
module tb_uart_tx_buffer;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       cke = 1'b1;
    logic       rst_soft = 1'b0;
    logic       tx_en = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       core_ready = 1'b0;
    logic       full, empty, overflow, core_wen;
    logic [4:0] level;
    logic [7:0] core_data;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    uart_tx_buffer #(
        .DATA_W  (8),
        .DEPTH_W (4)
    ) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .cke_i        (cke),
        .rst_soft_i   (rst_soft),
        .tx_en_i      (tx_en),
        .wr_en_i      (wr_en),
        .wr_data_i    (wr_data),
        .full_o       (full),
        .empty_o      (empty),
        .level_o      (level),
        .overflow_o   (overflow),
        .ovf_clr_i    (ovf_clr),
        .core_ready_i (core_ready),
        .core_data_o  (core_data),
        .core_wen_o   (core_wen)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        arst = 1'b1;
        step();
        step();
        n_total++;
        if ({level, empty, full, overflow, core_wen} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_flags: got %b expected %b", {level, empty, full, overflow, core_wen}, 9'b00000_1000);
        else n_pass++;
        n_total++;
        if (core_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", core_data);
        else n_pass++;
        arst = 1'b0;
        step();
        n_total++;
        if ({empty, core_wen} !== 2'b10) $display("FAIL reset_release: got %b expected 10", {empty, core_wen});
        else n_pass++;
    endtask

    task automatic test_latency();
        tx_en = 1'b1; core_ready = 1'b1;
        wr_en = 1'b1; wr_data = 8'h41;
        step();
        wr_en = 1'b0;
        n_total++;
        if ({level, core_wen} !== {5'd1, 1'b0}) $display("FAIL lat_n1: got level=%0d wen=%b expected level=1 wen=0", level, core_wen);
        else n_pass++;
        step();
        n_total++;
        if ({core_wen, core_data, level} !== {1'b1, 8'h41, 5'd0})
            $display("FAIL lat_n2: got wen=%b data=%h level=%0d expected wen=1 data=41 level=0", core_wen, core_data, level);
        else n_pass++;
        step();
        n_total++;
        if ({core_wen, core_data} !== {1'b0, 8'h41}) $display("FAIL lat_pulse: got wen=%b data=%h expected wen=0 data=41", core_wen, core_data);
        else n_pass++;
        step(); step();
    endtask

    task automatic test_overflow();
        tx_en = 1'b0; core_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = i[7:0];
            step();
        end
        wr_en = 1'b0;
        n_total++;
        if ({level, full, empty, overflow} !== {5'd16, 1'b1, 1'b0, 1'b0})
            $display("FAIL ovf_fill: got level=%0d full=%b empty=%b ovf=%b expected 16 1 0 0", level, full, empty, overflow);
        else n_pass++;
        wr_en = 1'b1; wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        n_total++;
        if ({level, overflow} !== {5'd16, 1'b1}) $display("FAIL ovf_set: got level=%0d ovf=%b expected 16 1", level, overflow);
        else n_pass++;
        wr_en = 1'b1; ovf_clr = 1'b1;
        step();
        wr_en = 1'b0;
        n_total++;
        if (overflow !== 1'b1) $display("FAIL ovf_set_priority: got %b expected 1", overflow);
        else n_pass++;
        step();
        ovf_clr = 1'b0;
        n_total++;
        if ({overflow, level} !== {1'b0, 5'd16}) $display("FAIL ovf_clear: got ovf=%b level=%0d expected 0 16", overflow, level);
        else n_pass++;
    endtask

    // Buffer holds 0x00..0x0F with pointers offset by one, so reading wraps.
    task automatic test_drain_wrap();
        int unsigned idx, busy, extra;
        logic prev_ready;
        idx = 0; busy = 0; extra = 0;
        tx_en = 1'b1; core_ready = 1'b1; prev_ready = 1'b1;
        wr_en = 1'b1; wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        n_total++;
        if ({level, overflow} !== {5'd15, 1'b1}) $display("FAIL full_push_pop: got level=%0d ovf=%b expected 15 1", level, overflow);
        else n_pass++;
        for (int cyc = 0; cyc < 600 && idx < 16; cyc++) begin
            if (cyc != 0) step();
            if (core_wen === 1'b1) begin
                n_total++;
                if (core_data !== idx[7:0]) $display("FAIL drain_order: got %h expected %h", core_data, idx[7:0]);
                else n_pass++;
                n_total++;
                if (prev_ready !== 1'b1) $display("FAIL drain_ready_low: got issue with ready=%b expected ready=1", prev_ready);
                else n_pass++;
                idx++;
                core_ready = 1'b0; busy = 10;
            end else if (busy != 0) begin
                busy--;
                if (busy == 0) core_ready = 1'b1;
            end
            prev_ready = core_ready;
        end
        n_total++;
        if (idx != 16) $display("FAIL drain_count: got %0d expected 16", idx);
        else n_pass++;
        for (int k = 0; k < 30; k++) begin
            step();
            if (core_wen === 1'b1) extra++;
            if (busy != 0) begin
                busy--;
                if (busy == 0) core_ready = 1'b1;
            end
        end
        n_total++;
        if (extra != 0) $display("FAIL drain_extra_wen: got %0d expected 0", extra);
        else n_pass++;
        n_total++;
        if ({level, empty} !== {5'd0, 1'b1}) $display("FAIL drain_empty: got level=%0d empty=%b expected 0 1", level, empty);
        else n_pass++;
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    endtask

    task automatic test_push_while_drain();
        int unsigned sent, rcvd;
        logic pushed;
        logic [4:0] exp_level;
        sent = 0; rcvd = 0; exp_level = 5'd0;
        tx_en = 1'b1; core_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && rcvd < 12; cyc++) begin
            pushed = (sent < 12);
            wr_en = pushed; wr_data = 8'h80 + sent[7:0];
            step();
            wr_en = 1'b0;
            if (pushed) sent++;
            if (core_wen === 1'b1) begin
                n_total++;
                if (core_data !== 8'h80 + rcvd[7:0]) $display("FAIL pd_order: got %h expected %h", core_data, 8'h80 + rcvd[7:0]);
                else n_pass++;
                rcvd++;
            end
            exp_level = exp_level + {4'd0, pushed} - {4'd0, core_wen};
            n_total++;
            if (level !== exp_level) $display("FAIL pd_level: got %0d expected %0d", level, exp_level);
            else n_pass++;
        end
        n_total++;
        if ({rcvd[4:0], level} !== {5'd12, 5'd0}) $display("FAIL pd_count: got rcvd=%0d level=%0d expected 12 0", rcvd, level);
        else n_pass++;
    endtask

    task automatic test_soft_reset();
        int unsigned wens;
        wens = 0;
        tx_en = 1'b0; core_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'h50 + i[7:0];
            step();
        end
        wr_en = 1'b0;
        tx_en = 1'b1;
        step();
        core_ready = 1'b0;
        n_total++;
        if ({core_wen, core_data, level} !== {1'b1, 8'h50, 5'd5})
            $display("FAIL sr_issue: got wen=%b data=%h level=%0d expected 1 50 5", core_wen, core_data, level);
        else n_pass++;
        step(); step(); step();
        rst_soft = 1'b1;
        step();
        rst_soft = 1'b0;
        n_total++;
        if ({level, empty, core_wen} !== {5'd0, 1'b1, 1'b0})
            $display("FAIL sr_state: got level=%0d empty=%b wen=%b expected 0 1 0", level, empty, core_wen);
        else n_pass++;
        core_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (core_wen === 1'b1) wens++;
        end
        n_total++;
        if (wens != 0) $display("FAIL sr_no_wen: got %0d expected 0", wens);
        else n_pass++;
        wr_en = 1'b1; wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        step();
        n_total++;
        if ({core_wen, core_data, level} !== {1'b1, 8'h77, 5'd0})
            $display("FAIL sr_idle_resume: got wen=%b data=%h level=%0d expected 1 77 0", core_wen, core_data, level);
        else n_pass++;
        step(); step(); step();
    endtask

    task automatic test_cke();
        int unsigned got, lat;
        got = 0; lat = 0;
        tx_en = 1'b0; core_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'h30 + i[7:0];
            step();
        end
        wr_en = 1'b0;
        cke = 1'b0; tx_en = 1'b1; wr_data = 8'hA0;
        for (int i = 0; i < 8; i++) begin
            wr_en = i[0]; core_ready = ~i[0];
            step();
            n_total++;
            if ({level, empty, full, overflow, core_wen, core_data} !== {5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77})
                $display("FAIL cke_frozen: got level=%0d empty=%b full=%b ovf=%b wen=%b data=%h expected 3 0 0 0 0 77",
                         level, empty, full, overflow, core_wen, core_data);
            else n_pass++;
        end
        wr_en = 1'b0; core_ready = 1'b1; cke = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            step();
            if (core_wen === 1'b1) begin
                if (got == 0) lat = cyc + 1;
                n_total++;
                if (core_data !== 8'h30 + got[7:0]) $display("FAIL cke_resume_order: got %h expected %h", core_data, 8'h30 + got[7:0]);
                else n_pass++;
                got++;
            end
        end
        n_total++;
        if ({got[3:0], lat[3:0], level} !== {4'd3, 4'd1, 5'd0})
            $display("FAIL cke_resume: got count=%0d first_lat=%0d level=%0d expected 3 1 0", got, lat, level);
        else n_pass++;
        step(); step(); step();
    endtask

    task automatic test_async_abort();
        int unsigned wens;
        wens = 0;
        tx_en = 1'b1; core_ready = 1'b1;
        wr_en = 1'b1; wr_data = 8'h99;
        step();
        wr_en = 1'b0;
        #2 arst = 1'b1;
        #1;
        n_total++;
        if ({level, empty, core_wen, core_data} !== {5'd0, 1'b1, 1'b0, 8'h00})
            $display("FAIL arst_mid: got level=%0d empty=%b wen=%b data=%h expected 0 1 0 00", level, empty, core_wen, core_data);
        else n_pass++;
        step(); step();
        arst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (core_wen === 1'b1) wens++;
        end
        n_total++;
        if ({wens[3:0], level} !== {4'd0, 5'd0}) $display("FAIL arst_no_wen: got wens=%0d level=%0d expected 0 0", wens, level);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_drain_wrap();
        test_push_while_drain();
        test_soft_reset();
        test_cke();
        test_async_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
